// File: rtl/biquad_sequencer.sv
// biquad_sequencer: control stage ahead of one biquad section.
// It accepts a float32 sample, shifts the x0/x1/x2 history, and waits out the
// filter FPU latency. It then pulses the filter start for one cycle, captures
// y0 and offers it downstream.
// Optional feature macro: BIQUAD_SEQ_BYPASS_EN adds i_bypass. A bypassed sample
// shifts the history and goes straight to the output without touching the filter.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Valid must not depend on ready. A source holds its data stable while
// valid is high and ready is low.
//
// o_dbg_state exposes the FSM encoding:
//   0 = IDLE, 1 = WAIT, 2 = FIRE, 3 = LATCH, 4 = OUT.

module biquad_sequencer #(
  parameter int FILTER_LATENCY = 25
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_sample,
`ifdef BIQUAD_SEQ_BYPASS_EN
  input  logic        i_bypass,
`endif
  output logic [31:0] o_x0,
  output logic [31:0] o_x1,
  output logic [31:0] o_x2,
  output logic        o_start,
  input  logic [31:0] i_y0,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_sample,
  output logic [2:0]  o_dbg_state
);

  // Wait-counter width is derived from the latency and is not meant to be overridden.
  localparam int CNT_W = $clog2(FILTER_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_FIRE  = 3'd2,
    S_LATCH = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             alive_q;
  logic             accept;
  logic             bypass_sel;

`ifdef BIQUAD_SEQ_BYPASS_EN
  assign bypass_sel = i_bypass;
`else
  assign bypass_sel = 1'b0;
`endif

  assign o_dbg_state = state_q;

  // Next-state and output decode; every output is a function of the current state.
  always_comb begin
    state_d     = state_q;
    o_in_ready  = 1'b0;
    o_start     = 1'b0;
    o_out_valid = 1'b0;
    accept      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // alive_q keeps ready low while reset is asserted and for the first edge after release.
        o_in_ready = alive_q;
        if (i_in_valid && alive_q) begin
          accept  = 1'b1;
          state_d = bypass_sel ? S_OUT : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_FIRE;
      end
      S_FIRE: begin
        o_start = 1'b1;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        state_d = S_OUT;
      end
      S_OUT: begin
        o_out_valid = 1'b1;
        if (i_out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; the alive flag marks the first cycle after reset release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  // Latency counter: loaded on accept; it counts FILTER_LATENCY WAIT cycles down to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= CNT_W'(FILTER_LATENCY - 1);
    end else if (state_q == S_WAIT && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Input history shifts only on an accepted sample, so the filter sees stable x values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_x0 <= '0;
      o_x1 <= '0;
      o_x2 <= '0;
    end else if (accept) begin
      o_x2 <= o_x1;
      o_x1 <= o_x0;
      o_x0 <= i_in_sample;
    end
  end

  // Output register: y0 is captured in LATCH, after the filter has updated on FIRE's closing edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out_sample <= '0;
    end else if (state_q == S_LATCH) begin
      o_out_sample <= i_y0;
    end else if (accept && bypass_sel) begin
      o_out_sample <= i_in_sample;
    end
  end

endmodule

// File: tb/tb_biquad_sequencer.sv
// Testbench for biquad_sequencer with FILTER_LATENCY=4 and a stub filter.
// The stub produces y0 from x0/x1/x2 when start is pulsed. The reference model
// keeps its own sample history and predicts both the filtered values and the
// cycle timing of start and out_valid.

module tb_biquad_sequencer;

  localparam int LAT = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_sample = '0;
  logic [31:0] x0, x1, x2;
  logic        start;
  logic [31:0] y0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sample;
  logic [2:0]  dbg_state;
`ifdef BIQUAD_SEQ_BYPASS_EN
  logic        bypass = 1'b0;
`endif

  biquad_sequencer #(.FILTER_LATENCY(LAT)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_sample  (in_sample),
`ifdef BIQUAD_SEQ_BYPASS_EN
    .i_bypass     (bypass),
`endif
    .o_x0         (x0),
    .o_x1         (x1),
    .o_x2         (x2),
    .o_start      (start),
    .i_y0         (y0),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_sample (out_sample),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- stub filter ----------------
  function automatic logic [31:0] stub_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
    return a ^ {b[23:0], b[31:24]} ^ (c + 32'h9E3779B9);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y0 <= '0;
    else if (start) y0 <= stub_fn(x0, x1, x2);
  end

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q[$];
  logic [31:0] hist[3] = '{32'h0, 32'h0, 32'h0};
  int          n_cmp = 0;
  int          n_err = 0;
  int          start_total = 0;
  int          exp_starts = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Counts every start pulse seen after each rising edge.
  always @(posedge clk) begin
    #1;
    if (start === 1'b1) start_total++;
  end

  task automatic model_accept(input logic [31:0] s, input bit filtered);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = s;
    if (filtered) begin
      exp_q.push_back(stub_fn(hist[0], hist[1], hist[2]));
      exp_starts++;
    end else begin
      exp_q.push_back(s);
    end
  endtask

  task automatic check_hist(input string tag);
    check({tag, "_x0"}, x0, hist[0]);
    check({tag, "_x1"}, x1, hist[1]);
    check({tag, "_x2"}, x2, hist[2]);
  endtask

  // ---------------- driver tasks ----------------
  // Called at #1 after a rising edge with the DUT expected in IDLE.
  task automatic drive_accept(input logic [31:0] s);
    check("accept_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_sample = s;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_sample = $urandom;
  endtask

  // Holds downstream off for 'hold' cycles while upstream pushes junk, then drains one output.
  task automatic drain_output(input int hold);
    logic [31:0] exp_v;
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      in_sample = $urandom;
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_start", 32'(start), 32'd0);
      check("bp_sample", out_sample, exp_q[0]);
      check("bp_x0", x0, hist[0]);
    end
    exp_v = exp_q.pop_front();
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_sample", out_sample, exp_v);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_hs_valid", 32'(out_valid), 32'd0);
    check("post_hs_ready", 32'(in_ready), 32'd1);
    check("post_hs_x0", x0, hist[0]);
  endtask

  // One filtered sample: accept, timing of start and out_valid, history, then output.
  task automatic send(input logic [31:0] s, input int hold);
    int start_d;
    drive_accept(s);
    model_accept(s, 1'b1);
    check_hist("acc");
    start_d = -1;
    for (int d = 1; d <= 20; d++) begin
      if (start_d < 0) begin
        @(posedge clk); #1;
        if (start === 1'b1) begin
          start_d = d;
          check_hist("fire");
        end
      end
    end
    check("start_delay", 32'(start_d), 32'(LAT));
    @(posedge clk); #1;
    check("start_width", 32'(start), 32'd0);
    check("valid_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("valid_delay", 32'(out_valid), 32'd1);
    drain_output(hold);
  endtask

  task automatic reset_in_wait(input logic [31:0] s);
    drive_accept(s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_x0", x0, 32'd0);
    check("rst_x1", x1, 32'd0);
    check("rst_out_sample", out_sample, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_start", 32'(start), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;
    hist = '{32'h0, 32'h0, 32'h0};
    exp_q.delete();
    for (int i = 0; i < LAT + 4; i++) begin
      @(posedge clk); #1;
      check("rel_start", 32'(start), 32'd0);
    end
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_out_valid", 32'(out_valid), 32'd0);
    check_hist("rel");
  endtask

`ifdef BIQUAD_SEQ_BYPASS_EN
  task automatic send_bypass(input logic [31:0] s);
    bypass = 1'b1;
    drive_accept(s);
    bypass = 1'b0;
    model_accept(s, 1'b0);
    check("byp_valid", 32'(out_valid), 32'd1);
    check("byp_start", 32'(start), 32'd0);
    check_hist("byp");
    drain_output(2);
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] s;
    // Reset: all outputs zero while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check("init_x0", x0, 32'd0);
    check("init_out_sample", out_sample, 32'd0);
    check("init_start", 32'(start), 32'd0);
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_in_ready", 32'(in_ready), 32'd0);
    check("init_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready0", 32'(in_ready), 32'd1);
    check("rel_out_valid0", 32'(out_valid), 32'd0);

    // Directed 1.0, 2.0, 3.0; the 2.0 sample waits 10 cycles under backpressure.
    send(32'h3F800000, 0);
    send(32'h40000000, 10);
    send(32'h40400000, 1);

    // Reset during WAIT cancels the pending start.
    reset_in_wait(32'h3F000000);

    // Randomized samples including special float patterns.
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 5))
        0: s = 32'h7FC00001;
        1: s = 32'hFF800000;
        2: s = 32'h00000003;
        default: s = $urandom;
      endcase
      send(s, $urandom_range(0, 5));
`ifdef BIQUAD_SEQ_BYPASS_EN
      if ($urandom_range(0, 2) == 0) send_bypass($urandom);
`endif
    end

    @(posedge clk); #1;
    check("start_total", 32'(start_total), 32'(exp_starts));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
